// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through to writeback, and issues LDW/STW accesses to
// data memory. An access stalls upstream until ack or a timeout abort.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef OP_LDW
`define OP_LDW 8'h40
`endif
`ifndef OP_STW
`define OP_STW 8'h41
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [`PC_WIDTH-1:0]     I_PC,
  input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [`IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [`REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]               I_CCValue,
  input  logic                     I_EX_Valid,
  input  logic [`REG_WIDTH-1:0]    I_MARValue,
  input  logic [`REG_WIDTH-1:0]    I_MDRValue,
  input  logic                     I_RegWEn,
  input  logic                     I_CCWEn,
  output logic                     O_DMemReq,
  output logic                     O_DMemWE,
  output logic [`REG_WIDTH-1:0]    O_DMemAddr,
  output logic [`REG_WIDTH-1:0]    O_DMemWData,
  input  logic                     I_DMemAck,
  input  logic [`REG_WIDTH-1:0]    I_DMemRData,
  output logic                     O_MEMStall_Signal,
  output logic                     O_RegWEn_Signal,
  output logic                     O_CCWEn_Signal,
  output logic                     O_LOCK,
  output logic [`OPCODE_WIDTH-1:0] O_Opcode,
  output logic [`PC_WIDTH-1:0]     O_PC,
  output logic [`IR_WIDTH-1:0]     O_IR,
  output logic [3:0]               O_DestRegIdx,
  output logic [`REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]               O_CCValue,
  output logic                     O_MEM_Valid,
  output logic                     O_RegWEn,
  output logic                     O_CCWEn,
  output logic                     O_MemError
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]         cnt;
  logic [`PC_WIDTH-1:0]     l_pc;
  logic [`IR_WIDTH-1:0]     l_ir;
  logic [`OPCODE_WIDTH-1:0] l_op;
  logic [3:0]               l_dst;
  logic [2:0]               l_cc;
  logic                     l_regwen, l_ccwen;
  logic [`REG_WIDTH-1:0]    l_mar, l_mdr;

  logic mem_op, l_stw, at_lim, ack, abort;
  logic [2:0] ld_cc;

  assign mem_op = I_LOCK & I_EX_Valid & ((I_Opcode == `OP_LDW) | (I_Opcode == `OP_STW));
  assign l_stw  = (l_op == `OP_STW);
  assign at_lim = (cnt >= LIM);
  assign ack    = (state == ACCESS) & I_DMemAck;
  assign abort  = (state == ACCESS) & ~I_DMemAck & at_lim;
  assign ld_cc  = I_DMemRData[`REG_WIDTH-1] ? 3'b100 :
                  (I_DMemRData == '0) ? 3'b010 : 3'b001;

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (mem_op) state_nx = ACCESS;
      ACCESS: if (ack || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is driven only while an access is outstanding, so it idles at zero.
  always_comb begin
    O_DMemReq   = (state == ACCESS);
    O_DMemWE    = (state == ACCESS) & l_stw;
    O_DMemAddr  = (state == ACCESS) ? {l_mar[`REG_WIDTH-1:2], 2'b00} : '0;
    O_DMemWData = (state == ACCESS) ? l_mdr : '0;
    O_MEMStall_Signal = ((state == IDLE) & mem_op) |
                        ((state == ACCESS) & ~I_DMemAck & ~at_lim);
    if (state == IDLE) begin
      O_RegWEn_Signal = I_RegWEn & I_LOCK & I_EX_Valid;
      O_CCWEn_Signal  = I_CCWEn & I_LOCK & I_EX_Valid;
    end else begin
      O_RegWEn_Signal = l_regwen & ~l_stw;
      O_CCWEn_Signal  = l_ccwen & ~l_stw;
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      cnt <= '0;
      l_pc <= '0; l_ir <= '0; l_op <= '0; l_dst <= '0; l_cc <= '0;
      l_regwen <= 1'b0; l_ccwen <= 1'b0; l_mar <= '0; l_mdr <= '0;
      O_LOCK <= 1'b0; O_Opcode <= '0; O_PC <= '0; O_IR <= '0;
      O_DestRegIdx <= '0; O_DestValue <= '0; O_CCValue <= '0;
      O_MEM_Valid <= 1'b0; O_RegWEn <= 1'b0; O_CCWEn <= 1'b0; O_MemError <= 1'b0;
    end else begin
      O_LOCK <= I_LOCK;
      case (state)
        IDLE: begin
          if (!I_LOCK) begin
            O_MEM_Valid <= 1'b0;
            O_RegWEn    <= 1'b0;
            O_CCWEn     <= 1'b0;
          end else if (mem_op) begin
            cnt <= '0;
            l_pc <= I_PC; l_ir <= I_IR; l_op <= I_Opcode; l_dst <= I_DestRegIdx;
            l_cc <= I_CCValue; l_regwen <= I_RegWEn; l_ccwen <= I_CCWEn;
            l_mar <= I_MARValue; l_mdr <= I_MDRValue;
            O_MEM_Valid <= 1'b0;
          end else begin
            O_PC <= I_PC; O_IR <= I_IR; O_Opcode <= I_Opcode;
            O_DestRegIdx <= I_DestRegIdx; O_DestValue <= I_DestValue;
            O_CCValue <= I_CCValue; O_RegWEn <= I_RegWEn; O_CCWEn <= I_CCWEn;
            O_MEM_Valid <= I_EX_Valid;
          end
        end
        ACCESS: begin
          if (ack || abort) begin
            O_PC <= l_pc; O_IR <= l_ir; O_Opcode <= l_op; O_DestRegIdx <= l_dst;
            O_MEM_Valid <= 1'b1;
          end
          if (ack) begin
            if (l_stw) begin
              O_DestValue <= l_mar;
              O_CCValue   <= l_cc;
              O_RegWEn    <= 1'b0;
              O_CCWEn     <= 1'b0;
            end else begin
              O_DestValue <= I_DMemRData;
              O_CCValue   <= l_ccwen ? ld_cc : l_cc;
              O_RegWEn    <= 1'b1;
              O_CCWEn     <= l_ccwen;
            end
          end else if (abort) begin
            O_DestValue <= '0;
            O_CCValue   <= l_cc;
            O_RegWEn    <= 1'b0;
            O_CCWEn     <= 1'b0;
            O_MemError  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            O_MEM_Valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, timeout abort, reset mid-access.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef OP_LDW
`define OP_LDW 8'h40
`endif
`ifndef OP_STW
`define OP_STW 8'h41
`endif

module tb_mem_stage;
  localparam logic [`OPCODE_WIDTH-1:0] OP_ADD = 8'h01;

  logic clk = 1'b0, rst;
  logic lock, ex_valid, regwen_i, ccwen_i, ack_i;
  logic [`PC_WIDTH-1:0] pc_i;
  logic [`OPCODE_WIDTH-1:0] op_i;
  logic [`IR_WIDTH-1:0] ir_i;
  logic [3:0] dst_i;
  logic [`REG_WIDTH-1:0] dval_i, mar_i, mdr_i, rdata_i;
  logic [2:0] cc_i;

  logic req, we, stall, rw_sig, cw_sig, lock_o, valid_o, regwen_o, ccwen_o, err_o;
  logic [`REG_WIDTH-1:0] addr, wdata, dval_o;
  logic [`OPCODE_WIDTH-1:0] op_o;
  logic [`PC_WIDTH-1:0] pc_o;
  logic [`IR_WIDTH-1:0] ir_o;
  logic [3:0] dst_o;
  logic [2:0] cc_o;

  int checks = 0, errors = 0, stalls;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_PC(pc_i), .I_Opcode(op_i), .I_IR(ir_i),
    .I_DestRegIdx(dst_i), .I_DestValue(dval_i), .I_CCValue(cc_i), .I_EX_Valid(ex_valid),
    .I_MARValue(mar_i), .I_MDRValue(mdr_i), .I_RegWEn(regwen_i), .I_CCWEn(ccwen_i),
    .O_DMemReq(req), .O_DMemWE(we), .O_DMemAddr(addr), .O_DMemWData(wdata),
    .I_DMemAck(ack_i), .I_DMemRData(rdata_i), .O_MEMStall_Signal(stall),
    .O_RegWEn_Signal(rw_sig), .O_CCWEn_Signal(cw_sig), .O_LOCK(lock_o), .O_Opcode(op_o),
    .O_PC(pc_o), .O_IR(ir_o), .O_DestRegIdx(dst_o), .O_DestValue(dval_o), .O_CCValue(cc_o),
    .O_MEM_Valid(valid_o), .O_RegWEn(regwen_o), .O_CCWEn(ccwen_o), .O_MemError(err_o)
  );

  always #5 clk = ~clk;

  task automatic drive_nop();
    lock = 1'b1; ex_valid = 1'b0; op_i = OP_ADD; pc_i = '0; ir_i = '0; dst_i = '0;
    dval_i = '0; cc_i = '0; mar_i = '0; mdr_i = '0; regwen_i = 1'b0; ccwen_i = 1'b0;
    ack_i = 1'b0; rdata_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_nop();
    @(posedge clk); @(negedge clk); #1;
    checks++; if (req !== 1'b0 || we !== 1'b0 || addr !== '0) begin errors++; $display("FAIL reset_port req=%b we=%b addr=%h exp 0", req, we, addr); end
    checks++; if (valid_o !== 1'b0 || regwen_o !== 1'b0 || ccwen_o !== 1'b0 || err_o !== 1'b0 || lock_o !== 1'b0) begin errors++; $display("FAIL reset_ctl v=%b rw=%b cw=%b err=%b lk=%b exp 0", valid_o, regwen_o, ccwen_o, err_o, lock_o); end
    checks++; if (dval_o !== '0 || pc_o !== '0 || cc_o !== 3'b000) begin errors++; $display("FAIL reset_data dval=%h pc=%h cc=%b exp 0", dval_o, pc_o, cc_o); end
    rst = 1'b0;
  endtask

  // ADD pass-through; an ack arriving while idle must have no effect.
  task automatic test_passthrough();
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; pc_i = 32'h100; dst_i = 4'd2; dval_i = 32'd5; cc_i = 3'b001;
    regwen_i = 1'b1; ccwen_i = 1'b1; ack_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL pass_stall stall=%b req=%b exp 0", stall, req); end
    checks++; if (rw_sig !== 1'b1 || cw_sig !== 1'b1) begin errors++; $display("FAIL pass_sig rw=%b cw=%b exp 1", rw_sig, cw_sig); end
    @(negedge clk); #1;
    checks++; if (dval_o !== 32'd5 || valid_o !== 1'b1 || cc_o !== 3'b001) begin errors++; $display("FAIL pass_out dval=%h v=%b cc=%b exp 5 1 001", dval_o, valid_o, cc_o); end
    checks++; if (pc_o !== 32'h100 || dst_o !== 4'd2 || regwen_o !== 1'b1 || lock_o !== 1'b1) begin errors++; $display("FAIL pass_fields pc=%h dst=%h rw=%b lk=%b", pc_o, dst_o, regwen_o, lock_o); end
  endtask

  // LDW at 0x1002, three wait cycles then ack at the timeout limit (ack wins).
  task automatic test_load_wait();
    stalls = 0;
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; op_i = `OP_LDW; pc_i = 32'h200; dst_i = 4'd3;
    mar_i = 32'h1002; regwen_i = 1'b1; ccwen_i = 1'b1; cc_i = 3'b010;
    #1; if (stall === 1'b1) stalls++;
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ld_bubble v=%b exp 0", valid_o); end
    for (int w = 0; w < 4; w++) begin
      @(posedge clk);
      ack_i = (w == 3); rdata_i = 32'hFFFF_FFFE;
      #1; if (stall === 1'b1) stalls++;
      checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h1000 || rw_sig !== 1'b1) begin errors++; $display("FAIL ld_port w=%0d req=%b we=%b addr=%h rw=%b exp 1 0 1000 1", w, req, we, addr, rw_sig); end
      @(negedge clk); #1;
    end
    checks++; if (stalls !== 4) begin errors++; $display("FAIL ld_stalls got %0d exp 4", stalls); end
    checks++; if (dval_o !== 32'hFFFF_FFFE || cc_o !== 3'b100 || regwen_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL ld_result dval=%h cc=%b rw=%b v=%b", dval_o, cc_o, regwen_o, valid_o); end
    checks++; if (dst_o !== 4'd3 || pc_o !== 32'h200 || ccwen_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL ld_fields dst=%h pc=%h cw=%b err=%b", dst_o, pc_o, ccwen_o, err_o); end
    @(posedge clk); drive_nop();
  endtask

  // Minimum-latency loads: zero and positive values set CC 010 / 001.
  task automatic test_load_cc();
    logic [`REG_WIDTH-1:0] vals [2];
    logic [2:0] ccs [2];
    vals[0] = 32'h0; ccs[0] = 3'b010; vals[1] = 32'h7; ccs[1] = 3'b001;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      drive_nop(); ex_valid = 1'b1; op_i = `OP_LDW; mar_i = 32'h44; regwen_i = 1'b1; ccwen_i = 1'b1;
      @(negedge clk);
      @(posedge clk);
      drive_nop(); ack_i = 1'b1; rdata_i = vals[k];
      @(negedge clk); #1;
      checks++; if (dval_o !== vals[k] || cc_o !== ccs[k] || valid_o !== 1'b1) begin errors++; $display("FAIL ld_cc%0d dval=%h cc=%b v=%b exp %h %b 1", k, dval_o, cc_o, valid_o, vals[k], ccs[k]); end
    end
    @(posedge clk); drive_nop();
  endtask

  // STW acked on first access cycle; I_LOCK drops during the access without aborting it.
  task automatic test_store();
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; op_i = `OP_STW; mar_i = 32'h20; mdr_i = 32'hABCD;
    cc_i = 3'b010; regwen_i = 1'b0; ccwen_i = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_issue_stall got %b exp 1", stall); end
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL st_bubble v=%b exp 0", valid_o); end
    @(posedge clk);
    drive_nop(); lock = 1'b0; ack_i = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || we !== 1'b1 || wdata !== 32'hABCD || addr !== 32'h20 || stall !== 1'b0) begin errors++; $display("FAIL st_port req=%b we=%b wd=%h addr=%h st=%b", req, we, wdata, addr, stall); end
    checks++; if (rw_sig !== 1'b0 || cw_sig !== 1'b0) begin errors++; $display("FAIL st_sig rw=%b cw=%b exp 0", rw_sig, cw_sig); end
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b1 || regwen_o !== 1'b0 || ccwen_o !== 1'b0 || dval_o !== 32'h20 || cc_o !== 3'b010 || lock_o !== 1'b0) begin errors++; $display("FAIL st_result v=%b rw=%b cw=%b dval=%h cc=%b lk=%b", valid_o, regwen_o, ccwen_o, dval_o, cc_o, lock_o); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL st_req_drop got %b exp 0", req); end
  endtask

  // I_LOCK low in IDLE: memory op is not issued and outputs go invalid.
  task automatic test_lock_low();
    @(posedge clk);
    drive_nop(); lock = 1'b0; ex_valid = 1'b1; op_i = `OP_LDW; mar_i = 32'h80; regwen_i = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || rw_sig !== 1'b0) begin errors++; $display("FAIL lk_comb st=%b rw=%b exp 0", stall, rw_sig); end
    @(negedge clk); #1;
    checks++; if (req !== 1'b0 || valid_o !== 1'b0 || regwen_o !== 1'b0) begin errors++; $display("FAIL lk_out req=%b v=%b rw=%b exp 0", req, valid_o, regwen_o); end
    @(posedge clk); drive_nop();
  endtask

  // No ack: abort after four access cycles, sticky error until reset.
  task automatic test_timeout();
    stalls = 0;
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; op_i = `OP_LDW; mar_i = 32'h300; regwen_i = 1'b1; ccwen_i = 1'b1;
    #1; if (stall === 1'b1) stalls++;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      @(posedge clk);
      #1; if (stall === 1'b1) stalls++;
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL to_req w=%0d got %b exp 1", w, req); end
      @(negedge clk); #1;
    end
    checks++; if (stalls !== 4) begin errors++; $display("FAIL to_stalls got %0d exp 4", stalls); end
    checks++; if (err_o !== 1'b1 || valid_o !== 1'b1 || regwen_o !== 1'b0 || ccwen_o !== 1'b0 || dval_o !== '0) begin errors++; $display("FAIL to_abort err=%b v=%b rw=%b cw=%b dval=%h", err_o, valid_o, regwen_o, ccwen_o, dval_o); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b exp 0", req); end
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; dval_i = 32'h9; regwen_i = 1'b1;
    @(negedge clk); #1;
    checks++; if (err_o !== 1'b1 || dval_o !== 32'h9) begin errors++; $display("FAIL to_sticky err=%b dval=%h exp 1 9", err_o, dval_o); end
  endtask

  // Reset on the 2nd access cycle, then a late ack must be ignored.
  task automatic test_reset_access();
    @(posedge clk); rst = 1'b1; drive_nop();
    @(negedge clk); #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rsa_err_clear got %b exp 0", err_o); end
    @(posedge clk);
    rst = 1'b0; ex_valid = 1'b1; op_i = `OP_LDW; mar_i = 32'h500; regwen_i = 1'b1;
    @(negedge clk);
    @(posedge clk); drive_nop();
    @(negedge clk);
    @(posedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (req !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL rsa_drop req=%b v=%b exp 0", req, valid_o); end
    @(posedge clk);
    rst = 1'b0; ack_i = 1'b1; rdata_i = 32'h1234;
    #1;
    checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rsa_late req=%b st=%b exp 0", req, stall); end
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b0 || regwen_o !== 1'b0 || err_o !== 1'b0 || dval_o !== '0) begin errors++; $display("FAIL rsa_ignored v=%b rw=%b err=%b dval=%h", valid_o, regwen_o, err_o, dval_o); end
    @(posedge clk);
    drive_nop(); ex_valid = 1'b1; dval_i = 32'h77;
    @(negedge clk); #1;
    checks++; if (valid_o !== 1'b1 || dval_o !== 32'h77) begin errors++; $display("FAIL rsa_idle v=%b dval=%h exp 1 77", valid_o, dval_o); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_wait();
    test_load_cc();
    test_store();
    test_lock_low();
    test_timeout();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles in ACCESS awaiting I_DMemAck before abort.
REQ-002 Ports, clock and reset first: I_CLOCK in 1; I_RESET in 1 (one clock; reset synchronous, active-high).
REQ-003 Upstream inputs from execute stage: I_LOCK in 1; I_PC in `PC_WIDTH; I_Opcode in `OPCODE_WIDTH; I_IR in `IR_WIDTH; I_DestRegIdx in 4; I_DestValue in `REG_WIDTH; I_CCValue in 3; I_EX_Valid in 1; I_MARValue in `REG_WIDTH; I_MDRValue in `REG_WIDTH; I_RegWEn in 1; I_CCWEn in 1.
REQ-004 Data-memory port: O_DMemReq out 1; O_DMemWE out 1; O_DMemAddr out `REG_WIDTH; O_DMemWData out `REG_WIDTH; I_DMemAck in 1; I_DMemRData in `REG_WIDTH.
REQ-005 Combinational outputs to earlier stages: O_MEMStall_Signal out 1 (upstream holds its outputs while high); O_RegWEn_Signal out 1; O_CCWEn_Signal out 1 (dependency check).
REQ-006 Registered outputs to writeback: O_LOCK 1; O_Opcode; O_PC; O_IR; O_DestRegIdx 4; O_DestValue `REG_WIDTH; O_CCValue 3; O_MEM_Valid 1; O_RegWEn 1; O_CCWEn 1; O_MemError 1 (sticky).

Function
REQ-007 All registers update on the falling edge of I_CLOCK, matching the pipeline.
REQ-008 FSM states: IDLE, ACCESS. Memory op = I_LOCK & I_EX_Valid & I_Opcode in {OP_LDW, OP_STW}.
REQ-009 IDLE, non-memory op: one-edge pass-through; O_PC/O_IR/O_Opcode/O_DestRegIdx/O_DestValue/O_CCValue/O_RegWEn/O_CCWEn <= inputs, O_MEM_Valid <= I_EX_Valid.
REQ-010 IDLE, memory op: latch instruction fields, MAR, MDR; go to ACCESS; O_MEM_Valid <= 0 (bubble).
REQ-011 O_MEMStall_Signal = (IDLE & memory op) | (ACCESS & ~I_DMemAck & counter < TIMEOUT_CYCLES-1).
REQ-012 ACCESS: O_DMemReq=1; O_DMemAddr = latched MAR with bits [1:0] forced 0; O_DMemWE=1 for STW, 0 for LDW; O_DMemWData = latched MDR; all held stable until ack or abort.
REQ-013 ACCESS with I_DMemAck=1 at an edge: LDW -> O_DestValue <= I_DMemRData, O_RegWEn <= 1; STW -> O_RegWEn <= 0, O_DestValue <= latched MAR; O_MEM_Valid <= 1; go to IDLE; O_DMemReq drops.
REQ-014 LDW CC: with latched I_CCWEn=1, O_CCValue <= 001 if loaded value signed >0, 100 if <0, 010 if ==0; STW keeps latched I_CCValue, O_CCWEn <= 0.
REQ-015 Minimum memory-op latency: two edges (issue edge, then ack edge); each extra wait cycle adds one edge.
REQ-016 Counter, 8 bits min, clears on entry to ACCESS and increments each ACCESS cycle without ack.
REQ-017 Timeout: counter reaching TIMEOUT_CYCLES-1 without ack -> abort: O_MEM_Valid <= 1, O_RegWEn <= 0, O_CCWEn <= 0, O_DestValue <= 0, O_MemError <= 1, go to IDLE.
REQ-018 Ack in the same cycle as the timeout limit: ack wins, no error.
REQ-019 I_DMemAck while IDLE is ignored.
REQ-020 I_LOCK=0 in IDLE: O_MEM_Valid, O_RegWEn, O_CCWEn <= 0, no access issued. I_LOCK falling during ACCESS does not abort the in-flight access.
REQ-021 O_LOCK <= I_LOCK every edge.
REQ-022 O_RegWEn_Signal/O_CCWEn_Signal = I_RegWEn/I_CCWEn gated by I_LOCK & I_EX_Valid in IDLE; in ACCESS = latched LDW values.

Reset
REQ-023 I_RESET=1 at an edge: state IDLE, counter 0, O_DMemReq 0, O_DMemWE 0, O_MEM_Valid 0, O_RegWEn 0, O_CCWEn 0, O_MemError 0, O_LOCK 0, all data outputs 0.
REQ-024 Reset during ACCESS drops the request at that edge; a late ack is ignored (REQ-019).
REQ-025 Reset takes priority over every other event.

Verification
REQ-026 ADD passing through, I_DestValue=5, I_CCValue=001 -> next edge O_DestValue=5, O_MEM_Valid=1, stall never high.
REQ-027 LDW MAR=0x1002, ack after 3 wait cycles, RData=0xFFFFFFFE -> O_DMemAddr=0x1000, WE=0; stall high 4 cycles; O_DestValue=0xFFFFFFFE, O_CCValue=100, O_RegWEn=1.
REQ-028 STW MAR=0x20, MDR=0xABCD, ack on first ACCESS cycle -> WE=1, WData=0xABCD; completes on 2nd edge; O_RegWEn=0.
REQ-029 LDW with no ack, TIMEOUT_CYCLES=4 -> abort after 4 ACCESS cycles, O_MemError=1, O_RegWEn=0; stays 1 until reset.
REQ-030 Reset asserted on 2nd ACCESS cycle, then ack -> O_DMemReq=0, O_MEM_Valid=0, ack ignored, state IDLE.
